dso_capture_ctrl: RTL and testbench
===================================

// Module: dso_capture_ctrl
// PURPOSE
//  Capture sequencer for the dual 8-bit ADC path. Writes {adc_a,adc_b} sample pairs into the
//  2^AW x 16 ADC buffer RAM as a ring, finds a level/edge trigger, and stops after a set
//  post-trigger count. Flags completion to the MCU for SPI readback; trig_addr locates the trigger.
// PARAMETERS
//  AW      12   buffer address width; DEPTH = 2^AW samples
// PORTS
//  clk        in   1    system clock; all logic on posedge clk
//  nrst       in   1    reset, asynchronous assert, active-low
//  sample_en  in   1    ADC sample strobe; one sample pair accepted per cycle it is high
//  adc_a_d    in   8    channel A sample
//  adc_b_d    in   8    channel B sample
//  arm        in   1    pulse: latch config, start capture
//  abort      in   1    pulse: stop capture, return to IDLE
//  force_trig in   1    MCU trigger_mcu line, level; forces trigger in WAIT_TRIG
//  trig_src   in   1    0 = channel A, 1 = channel B
//  trig_edge  in   1    0 = rising, 1 = falling
//  trig_level in   8    unsigned trigger threshold
//  pretrig    in   AW   samples retained before trigger (0..DEPTH-1)
//  mem_we     out  1    buffer RAM write enable
//  mem_addr   out  AW   buffer RAM write address
//  mem_data   out  16   buffer RAM write data {adc_a_d, adc_b_d}
//  trig_addr  out  AW   address holding the trigger sample
//  busy       out  1    high in PRE, WAIT_TRIG, POST
//  ready_mcu  out  1    high in DONE: buffer valid for readback
//  state      out  3    IDLE=0 PRE=1 WAIT_TRIG=2 POST=3 DONE=4
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal counters 0, prev-sample-valid cleared.
//  - arm (any state, abort low): latch trig_src/edge/level/pretrig; wr pointer := 0;
//    next state PRE, or WAIT_TRIG if pretrig = 0. Re-arm in DONE starts a new capture.
//  - abort: next cycle state IDLE, mem_we 0, ready_mcu 0. abort beats simultaneous arm.
//  - Accepted sample = sample_en high in PRE/WAIT_TRIG/POST. Sample accepted at cycle N:
//    mem_we=1, mem_addr=ptr, mem_data={a,b} registered, visible cycle N+1; ptr increments
//    mod DEPTH (wraps DEPTH-1 -> 0). No write in IDLE/DONE.
//  - PRE: counts accepted samples; after pretrig samples -> WAIT_TRIG. No trigger check.
//  - WAIT_TRIG: ring keeps overwriting. Trigger on an accepted sample s of selected channel:
//    rising: prev < level && s >= level; falling: prev > level && s <= level. Needs a valid
//    prev (>=1 sample accepted since arm), so first sample after arm never triggers.
//    force_trig high with an accepted sample also triggers. Triggering sample is written;
//    trig_addr := its address (valid N+1); post counter := DEPTH-1-pretrig.
//  - POST: write post-counter samples, then DONE in the cycle after the last write.
//    post count 0 (pretrig = DEPTH-1) -> DONE directly after the trigger sample.
//  - DONE: ready_mcu=1, busy=0, mem_we=0; buffer and trig_addr held until arm/abort.
//  - Oldest sample at trig_addr - pretrig (mod DEPTH); total DEPTH samples per capture.
//  - Reset mid-capture: immediate IDLE, no further writes; RAM contents unspecified.
// CONFIGURATION
//  DSO_DECIMATION_EN defined: adds input port decim [7:0] (latched on arm); only every
//    (decim+1)th sample_en strobe is accepted; decimation counter cleared on arm; decim=0
//    accepts every strobe. Trigger detection and prev use accepted samples only.
//  Undefined: no decim port; every sample_en strobe is accepted.
// TESTING
//  1 AW=4, pretrig=4, rising, level=0x80, chan A ramp 0x00,0x10.. each cycle -> trigger on
//    0x80, trig_addr=8 (4 pre + wait samples 4..7 -> ptr 8), 11 post writes, ready_mcu high.
//  2 pretrig=0, force_trig high at first sample after arm -> no trigger (no prev); trigger on
//    2nd sample, trig_addr=1, 15 post samples, DONE.
//  3 AW=4, pretrig=15, trigger after 20 waits -> mem_addr wraps 15->0; DONE right after trigger.
//  4 abort in POST with arm same cycle -> IDLE next cycle, mem_we 0, busy 0, ready_mcu 0.
//  5 nrst low mid WAIT_TRIG -> all outputs 0 asynchronously; arm after release restarts at 0.
//  6 DSO_DECIMATION_EN, decim=2, sample_en constant high -> mem_we every 3rd cycle.

Source files
------------

// File: rtl/dso_capture_ctrl.sv
// dso_capture_ctrl: capture sequencer for the dual 8-bit ADC path.
// Writes {adc_a_d, adc_b_d} pairs into a 2^AW ring buffer, detects a level/edge
// (or forced) trigger, then stops after the post-trigger fill.
// Optional build macro: DSO_DECIMATION_EN adds the decim input, which accepts
// only every (decim+1)th sample_en strobe.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no capture, no writes
// PRE       | filling the pre-trigger window, no trigger check
// WAIT_TRIG | ring keeps overwriting, looking for the trigger sample
// POST      | writing the post-trigger samples
// DONE      | buffer and trig_addr held for MCU readback
module dso_capture_ctrl #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          sample_en,
   input  logic [7:0]    adc_a_d,
   input  logic [7:0]    adc_b_d,
   input  logic          arm,
   input  logic          abort,
   input  logic          force_trig,
   input  logic          trig_src,
   input  logic          trig_edge,
   input  logic [7:0]    trig_level,
   input  logic [AW-1:0] pretrig,
`ifdef DSO_DECIMATION_EN
   input  logic [7:0]    decim,
`endif
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_data,
   output logic [AW-1:0] trig_addr,
   output logic          busy,
   output logic          ready_mcu,
   output logic [2:0]    state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE       = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam logic [AW-1:0] ONE = AW'(1);

   state_t        st, st_nxt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] cnt;
   logic [7:0]    prev;
   logic          prev_valid;
   logic          src_q;
   logic          edge_q;
   logic [7:0]    level_q;
   logic [AW-1:0] pretrig_q;
   logic          active;
   logic          strobe_ok;
   logic          accept;
   logic [7:0]    sel;
   logic          edge_hit;
   logic          hit;

`ifdef DSO_DECIMATION_EN
   logic [7:0]    decim_q;
   logic [7:0]    dcnt;
   assign strobe_ok = (dcnt == 8'd0);
`else
   assign strobe_ok = 1'b1;
`endif

   // Arm/abort restart the sequence, so the sample presented with them is dropped.
   assign active   = (st == PRE) || (st == WAIT_TRIG) || (st == POST);
   assign accept   = active && sample_en && strobe_ok && !abort && !arm;
   assign sel      = src_q ? adc_b_d : adc_a_d;
   assign edge_hit = edge_q ? ((prev > level_q) && (sel <= level_q))
                            : ((prev < level_q) && (sel >= level_q));
   // Without a previous sample there is no edge, and a forced trigger waits too.
   assign hit      = accept && (st == WAIT_TRIG) && prev_valid && (force_trig || edge_hit);

   assign busy      = active;
   assign ready_mcu = (st == DONE);
   assign state     = st;

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) st <= IDLE;
      else       st <= st_nxt;
   end

   // Next-state logic; abort outranks arm, arm outranks everything else.
   always_comb begin
      st_nxt = st;
      if (abort) begin
         st_nxt = IDLE;
      end else if (arm) begin
         st_nxt = (pretrig == '0) ? WAIT_TRIG : PRE;
      end else begin
         case (st)
            PRE:       if (accept && (cnt == ONE)) st_nxt = WAIT_TRIG;
            WAIT_TRIG: if (hit) st_nxt = (~pretrig_q == '0) ? DONE : POST;
            POST:      if (accept && (cnt == ONE)) st_nxt = DONE;
            default:   st_nxt = st;
         endcase
      end
   end

   // Write port, ring pointer, pre/post down-counter, trigger history and config latch.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         trig_addr  <= '0;
         ptr        <= '0;
         cnt        <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         src_q      <= 1'b0;
         edge_q     <= 1'b0;
         level_q    <= '0;
         pretrig_q  <= '0;
`ifdef DSO_DECIMATION_EN
         decim_q    <= '0;
         dcnt       <= '0;
`endif
      end else begin
         mem_we <= accept;
         if (accept) begin
            mem_addr   <= ptr;
            mem_data   <= {adc_a_d, adc_b_d};
            ptr        <= ptr + ONE;
            prev       <= sel;
            prev_valid <= 1'b1;
         end
         if (hit) begin
            trig_addr <= ptr;
            cnt       <= ~pretrig_q;
         end else if (accept && ((st == PRE) || (st == POST))) begin
            cnt <= cnt - ONE;
         end
`ifdef DSO_DECIMATION_EN
         if (active && sample_en && !abort && !arm)
            dcnt <= (dcnt == 8'd0) ? decim_q : dcnt - 8'd1;
`endif
         if (arm && !abort) begin
            src_q      <= trig_src;
            edge_q     <= trig_edge;
            level_q    <= trig_level;
            pretrig_q  <= pretrig;
            ptr        <= '0;
            cnt        <= pretrig;
            prev_valid <= 1'b0;
`ifdef DSO_DECIMATION_EN
            decim_q    <= decim;
            dcnt       <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Bench for dso_capture_ctrl (AW=4, default build). Expected RAM writes come
// from a capture model over the list of accepted samples and are queued; a
// monitor pops one entry for every mem_we the DUT presents.
module tb_dso_capture_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int NS    = 64;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          sample_en = 1'b0;
   logic [7:0]    adc_a_d = '0;
   logic [7:0]    adc_b_d = '0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          force_trig = 1'b0;
   logic          trig_src = 1'b0;
   logic          trig_edge = 1'b0;
   logic [7:0]    trig_level = '0;
   logic [AW-1:0] pretrig = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_data;
   logic [AW-1:0] trig_addr;
   logic          busy;
   logic          ready_mcu;
   logic [2:0]    state;

   dso_capture_ctrl #(.AW(AW)) dut (
      .clk(clk), .nrst(nrst), .sample_en(sample_en),
      .adc_a_d(adc_a_d), .adc_b_d(adc_b_d),
      .arm(arm), .abort(abort), .force_trig(force_trig),
      .trig_src(trig_src), .trig_edge(trig_edge), .trig_level(trig_level),
      .pretrig(pretrig),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .trig_addr(trig_addr), .busy(busy), .ready_mcu(ready_mcu), .state(state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_q[$];
   logic [19:0] mon_e;
   logic [7:0]  sa [NS];
   logic [7:0]  sb [NS];
   logic        frc [NS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every presented write must match the next queued expectation.
   always @(negedge clk) begin
      if (nrst && mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {12'd0, mem_addr, mem_data}, 32'hFFFFFFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(mon_e[19:16]));
            check("wr_data", 32'(mem_data), 32'(mon_e[15:0]));
         end
      end
   end

   task automatic flat_stim(input int force_at);
      for (int k = 0; k < NS; k++) begin
         sa[k]  = 8'h00;
         sb[k]  = 8'($urandom_range(0, 255));
         frc[k] = 1'b0;
      end
      frc[force_at] = 1'b1;
   endtask

   // One capture: model, arm, feed samples with random gaps, then check the end.
   // abort_after / reset_after >= 0 cut the capture short after that many samples.
   task automatic run_capture(input int pre, input logic src, input logic edg,
                              input logic [7:0] lvl, input int abort_after,
                              input int reset_after);
      int tk, nwr, stop, j, cyc, phase;
      logic [7:0] s, p;
      tk = NS - 1;
      for (int k = 1; k < NS; k++) begin
         s = src ? sb[k] : sa[k];
         p = src ? sb[k-1] : sa[k-1];
         if (k >= pre && (frc[k] || (edg ? (p > lvl && s <= lvl) : (p < lvl && s >= lvl)))) begin
            tk = k;
            break;
         end
      end
      nwr  = tk + 1 + (DEPTH - 1 - pre);
      stop = nwr;
      if (abort_after >= 0) stop = abort_after;
      if (reset_after >= 0) stop = reset_after;
      for (int k = 0; k < stop; k++) exp_q.push_back({AW'(k % DEPTH), sa[k], sb[k]});
      phase = (stop < pre) ? 1 : (stop <= tk) ? 2 : (stop < nwr) ? 3 : 4;

      @(posedge clk); #1;
      arm = 1'b1; trig_src = src; trig_edge = edg; trig_level = lvl;
      pretrig = AW'(pre); sample_en = 1'b1; adc_a_d = 8'hEE; adc_b_d = 8'hEE;
      @(posedge clk); #1;
      arm = 1'b0; sample_en = 1'b0;
      trig_src = ~src; trig_edge = ~edg; trig_level = ~lvl; pretrig = ~AW'(pre);
      @(negedge clk);
      check("arm_state", 32'(state), (pre == 0) ? 32'd2 : 32'd1);
      check("arm_busy", 32'(busy), 32'd1);

      j = 0; cyc = 0;
      while (j < stop && cyc < 500) begin
         @(posedge clk); #1; cyc++;
         if ($urandom_range(0, 3) != 0) begin
            sample_en = 1'b1; adc_a_d = sa[j]; adc_b_d = sb[j]; force_trig = frc[j];
            j++;
         end else begin
            sample_en = 1'b0; force_trig = 1'($urandom_range(0, 1));
            adc_a_d = 8'($urandom_range(0, 255)); adc_b_d = 8'($urandom_range(0, 255));
         end
      end
      check("stim_budget", 32'(j), 32'(stop));
      @(posedge clk); #1;
      sample_en = 1'b0; force_trig = 1'b0;
      if (abort_after >= 0) begin
         abort = 1'b1; arm = 1'b1; sample_en = 1'b1; adc_a_d = sa[j]; adc_b_d = sb[j];
      end
      @(negedge clk);
      check("phase_state", 32'(state), 32'(phase));

      if (abort_after >= 0) begin
         @(posedge clk); #1;
         abort = 1'b0; arm = 1'b0; sample_en = 1'b1;
         @(negedge clk);
         check("abort_state", 32'(state), 32'd0);
         check("abort_we", 32'(mem_we), 32'd0);
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_ready", 32'(ready_mcu), 32'd0);
         @(posedge clk); #1; sample_en = 1'b0;
         @(negedge clk);
         check("idle_no_write", 32'(mem_we), 32'd0);
      end else if (reset_after >= 0) begin
         #2; nrst = 1'b0; sample_en = 1'b1;
         #1;
         check("rst_outputs", {12'd0, mem_we, busy, ready_mcu, state, mem_addr, trig_addr}, 32'd0);
         check("rst_data", 32'(mem_data), 32'd0);
         @(posedge clk); #1;
         @(posedge clk); #1; nrst = 1'b1; sample_en = 1'b0;
         @(negedge clk);
         check("rst_release_state", 32'(state), 32'd0);
      end else begin
         check("done_ready", 32'(ready_mcu), 32'd1);
         check("done_busy", 32'(busy), 32'd0);
         check("trig_addr", 32'(trig_addr), 32'(tk % DEPTH));
         repeat (4) begin
            @(posedge clk); #1;
            sample_en = 1'b1; force_trig = 1'($urandom_range(0, 1));
            adc_a_d = 8'($urandom_range(0, 255)); adc_b_d = 8'($urandom_range(0, 255));
         end
         @(negedge clk);
         check("done_hold_state", 32'(state), 32'd4);
         check("done_hold_trig", 32'(trig_addr), 32'(tk % DEPTH));
         @(posedge clk); #1; sample_en = 1'b0; force_trig = 1'b0;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {12'd0, mem_we, busy, ready_mcu, state, mem_addr, trig_addr}, 32'd0);
      nrst = 1'b1;
      @(negedge clk);
      check("idle_state", 32'(state), 32'd0);

      // Rising ramp on channel A, trigger expected on 0x80 at address 8.
      flat_stim(40);
      for (int k = 0; k < NS; k++) sa[k] = 8'(k * 16);
      run_capture(4, 1'b0, 1'b0, 8'h80, -1, -1);

      // pretrig 0: force on the very first sample is ignored, second one triggers.
      flat_stim(1);
      frc[0] = 1'b1;
      run_capture(0, 1'b0, 1'b0, 8'h80, -1, -1);

      // pretrig DEPTH-1: pointer wraps, DONE right after the trigger sample.
      flat_stim(20);
      run_capture(15, 1'b0, 1'b0, 8'h80, -1, -1);

      // Abort together with arm while in POST.
      flat_stim(5);
      run_capture(2, 1'b1, 1'b1, 8'h40, 8, -1);

      // Reset in WAIT_TRIG, next capture must restart at address 0.
      flat_stim(40);
      run_capture(3, 1'b0, 1'b0, 8'h80, -1, 6);

      // Randomized captures on both channels and both edges.
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < NS; k++) begin
            sa[k]  = 8'($urandom_range(0, 255));
            sb[k]  = 8'($urandom_range(0, 255));
            frc[k] = ($urandom_range(0, 15) == 0);
         end
         frc[40] = 1'b1;
         run_capture($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), (r == 7) ? 3 : -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
